// File: rtl/missile_ctl.sv
// missile_ctl: player missile launch/flight FSM plus pixel overlay stage, 1-cycle latency.
// Optional feature: define MISSILE_HIT_EN to add the `hit` input that ends a flight early.
`default_nettype none

module missile_ctl #(
  parameter int          MISSILE_W       = 4,
  parameter int          MISSILE_H       = 16,
  parameter int          SPEED           = 8,
  parameter int          X_OFFSET        = 30,
  parameter int          COOLDOWN_FRAMES = 10,
  parameter logic [11:0] COLOR           = 12'hFF0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        fire,
`ifdef MISSILE_HIT_EN
  input  logic        hit,
`endif
  input  logic [10:0] xpos_player,
  input  logic [10:0] ypos_player,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out,
  output logic [10:0] xpos_missile,
  output logic [10:0] ypos_missile,
  output logic        on_missle
);

  localparam logic [1:0]  IDLE     = 2'd0;
  localparam logic [1:0]  FLY      = 2'd1;
  localparam logic [1:0]  COOLDOWN = 2'd2;

  localparam logic [10:0] MH   = 11'(MISSILE_H);
  localparam logic [10:0] SPD  = 11'(SPEED);
  localparam logic [10:0] XOFF = 11'(X_OFFSET);
  localparam logic [7:0]  CD   = 8'(COOLDOWN_FRAMES);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cooldown_q, cooldown_d;
  logic        fire_pending_q, fire_pending_d;
  logic        fire_prev_q, vblnk_prev_q;
  logic [10:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic        on_q, on_d;
  logic [11:0] rgb_q, rgb_d;
  logic [10:0] vcount_q, hcount_q;
  logic        vsync_q, vblnk_q, hsync_q, hblnk_q;

  logic tick, press, hit_now;
  logic in_x, in_y;

  assign tick  = vblnk_in & ~vblnk_prev_q;
  assign press = fire & ~fire_prev_q;
`ifdef MISSILE_HIT_EN
  assign hit_now = hit;
`else
  assign hit_now = 1'b0;
`endif

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cooldown_q     <= '0;
      fire_pending_q <= 1'b0;
      fire_prev_q    <= 1'b0;
      vblnk_prev_q   <= 1'b0;
      xpos_q         <= '0;
      ypos_q         <= '0;
      on_q           <= 1'b0;
      rgb_q          <= '0;
      vcount_q       <= '0;
      hcount_q       <= '0;
      vsync_q        <= 1'b0;
      vblnk_q        <= 1'b0;
      hsync_q        <= 1'b0;
      hblnk_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cooldown_q     <= cooldown_d;
      fire_pending_q <= fire_pending_d;
      fire_prev_q    <= fire;
      vblnk_prev_q   <= vblnk_in;
      xpos_q         <= xpos_d;
      ypos_q         <= ypos_d;
      on_q           <= on_d;
      rgb_q          <= rgb_d;
      vcount_q       <= vcount_in;
      hcount_q       <= hcount_in;
      vsync_q        <= vsync_in;
      vblnk_q        <= vblnk_in;
      hsync_q        <= hsync_in;
      hblnk_q        <= hblnk_in;
    end
  end

  always_comb begin
    state_d        = state_q;
    cooldown_d     = cooldown_q;
    fire_pending_d = 1'b0;
    xpos_d         = xpos_q;
    ypos_d         = ypos_q;
    on_d           = on_q;
    case (state_q)
      IDLE: begin
        // A press in the tick cycle itself still counts toward this frame's launch.
        fire_pending_d = tick ? 1'b0 : (fire_pending_q | press);
        if (tick && (fire_pending_q || press) && (ypos_player >= MH)) begin
          xpos_d  = xpos_player + XOFF;
          ypos_d  = ypos_player - MH;
          on_d    = 1'b1;
          state_d = FLY;
        end
      end
      FLY: begin
        if (hit_now || (tick && (ypos_q < SPD))) begin
          on_d       = 1'b0;
          cooldown_d = CD;
          state_d    = COOLDOWN;
        end else if (tick) begin
          ypos_d = ypos_q - SPD;
        end
      end
      COOLDOWN: begin
        if (tick) begin
          cooldown_d = cooldown_q - 8'd1;
          if (cooldown_q <= 8'd1) begin
            cooldown_d = '0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Extents computed in 12 bits so a missile near x=2047 does not wrap its box.
  always_comb begin
    in_x  = (hcount_in >= xpos_q) && ({1'b0, hcount_in} < ({1'b0, xpos_q} + 12'(MISSILE_W)));
    in_y  = (vcount_in >= ypos_q) && ({1'b0, vcount_in} < ({1'b0, ypos_q} + 12'(MISSILE_H)));
    rgb_d = rgb_in;
    if (hblnk_in || vblnk_in)
      rgb_d = 12'h000;
    else if (on_q && in_x && in_y)
      rgb_d = COLOR;
  end

  always_comb begin
    xpos_missile = xpos_q;
    ypos_missile = ypos_q;
    on_missle    = on_q;
    rgb_out      = rgb_q;
    vcount_out   = vcount_q;
    hcount_out   = hcount_q;
    vsync_out    = vsync_q;
    vblnk_out    = vblnk_q;
    hsync_out    = hsync_q;
    hblnk_out    = hblnk_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_missile_ctl.sv
// tb_missile_ctl: scoreboard bench for missile_ctl using directed vectors.
`default_nettype none

module tb_missile_ctl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        fire;
  logic        hit;
  logic [10:0] xpos_player, ypos_player, vcount_in, hcount_in;
  logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] vcount_out, hcount_out, xpos_missile, ypos_missile;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out, on_missle;
  logic [11:0] rgb_out;

  missile_ctl dut (
    .pclk(pclk), .rst(rst), .fire(fire),
`ifdef MISSILE_HIT_EN
    .hit(hit),
`endif
    .xpos_player(xpos_player), .ypos_player(ypos_player),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .vblnk_in(vblnk_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .vblnk_out(vblnk_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out),
    .xpos_missile(xpos_missile), .ypos_missile(ypos_missile), .on_missle(on_missle)
  );

  always #5 pclk = ~pclk;

  // kind 0: position/on, 1: rgb, 2: timing pass-through, 3: all outputs zero
  typedef struct {
    int          kind;
    string       name;
    logic [10:0] x;
    logic [10:0] y;
    logic        on;
    logic [11:0] rgb;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic push(input int kind, input string name, input logic [10:0] x,
                      input logic [10:0] y, input logic on, input logic [11:0] rgb);
    exp_t e;
    e.kind = kind; e.name = name; e.x = x; e.y = y; e.on = on; e.rgb = rgb; e.due = cyc;
    sb.push_back(e);
  endtask

  always @(negedge pclk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      n_tests++;
      case (mon_e.kind)
        0: if ({xpos_missile, ypos_missile, on_missle} !== {mon_e.x, mon_e.y, mon_e.on}) begin
             n_fail++;
             $display("FAIL %s: got x=%0d y=%0d on=%0b, want x=%0d y=%0d on=%0b", mon_e.name,
                      xpos_missile, ypos_missile, on_missle, mon_e.x, mon_e.y, mon_e.on);
           end
        1: if (rgb_out !== mon_e.rgb) begin
             n_fail++;
             $display("FAIL %s: got rgb=%h, want rgb=%h", mon_e.name, rgb_out, mon_e.rgb);
           end
        2: if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}
               !== {mon_e.x, mon_e.y, mon_e.rgb[3:0]}) begin
             n_fail++;
             $display("FAIL %s: got h=%0d v=%0d sync/blnk=%b%b%b%b, want h=%0d v=%0d sync/blnk=%b",
                      mon_e.name, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
                      vblnk_out, mon_e.x, mon_e.y, mon_e.rgb[3:0]);
           end
        default: if ({xpos_missile, ypos_missile, on_missle, rgb_out, hcount_out, vcount_out,
                      hsync_out, vsync_out, hblnk_out, vblnk_out} !== '0) begin
             n_fail++;
             $display("FAIL %s: got x=%0d y=%0d on=%0b rgb=%h h=%0d v=%0d, want all zero",
                      mon_e.name, xpos_missile, ypos_missile, on_missle, rgb_out,
                      hcount_out, vcount_out);
           end
      endcase
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic tick();
    vblnk_in = 1'b1; step(); step();
    vblnk_in = 1'b0; step();
  endtask

  task automatic press();
    fire = 1'b1; step();
    fire = 1'b0; step();
  endtask

  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic hb,
                     input logic [11:0] c);
    hcount_in = h; vcount_in = v; hblnk_in = hb; rgb_in = c;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ey;
    rst = 1'b0; fire = 1'b0; hit = 1'b0;
    xpos_player = '0; ypos_player = '0; vcount_in = '0; hcount_in = '0;
    vsync_in = 1'b0; vblnk_in = 1'b0; hsync_in = 1'b0; hblnk_in = 1'b0; rgb_in = '0;
    repeat (3) step();
    push(3, "reset_state", 0, 0, 0, 0);
    step();
    rst = 1'b1;
    step();

    xpos_player = 11'd500; ypos_player = 11'd700;
    press(); tick();
    push(0, "launch", 11'd530, 11'd684, 1'b1, 0);

    hsync_in = 1'b1; vsync_in = 1'b1;
    pix(11'd531, 11'd690, 1'b0, 12'h123);
    push(1, "pix_inside", 0, 0, 0, 12'hFF0);
    push(2, "timing_delay", 11'd531, 11'd690, 0, 12'h00C);
    hsync_in = 1'b0; vsync_in = 1'b0;
    pix(11'd534, 11'd690, 1'b0, 12'h123); push(1, "pix_right_of", 0, 0, 0, 12'h123);
    pix(11'd533, 11'd690, 1'b0, 12'h456); push(1, "pix_last_col", 0, 0, 0, 12'hFF0);
    pix(11'd530, 11'd684, 1'b0, 12'h456); push(1, "pix_top_left", 0, 0, 0, 12'hFF0);
    pix(11'd531, 11'd700, 1'b0, 12'h789); push(1, "pix_below", 0, 0, 0, 12'h789);
    pix(11'd531, 11'd690, 1'b1, 12'h789); push(1, "pix_hblnk", 0, 0, 0, 12'h000);
    hblnk_in = 1'b0;

    tick();
    push(0, "move", 11'd530, 11'd676, 1'b1, 0);
    ey = 676;
    while (ey >= 8) begin
      tick();
      ey -= 8;
    end
    push(0, "fly_top", 11'd530, 11'(ey), 1'b1, 0);
    tick();
    push(0, "exit_top", 11'd530, 11'd4, 1'b0, 0);

    ypos_player = 11'd416;
    for (int i = 0; i < 10; i++) begin
      press(); tick();
      push(0, "cooldown_discard", 11'd530, 11'd4, 1'b0, 0);
    end
    press(); tick();
    push(0, "relaunch", 11'd530, 11'd400, 1'b1, 0);

    hcount_in = 11'd100; hsync_in = 1'b1;
    step();
    @(posedge pclk);
    #2;
    rst = 1'b0;
    push(3, "async_reset", 0, 0, 0, 0);
    step();
    rst = 1'b1;
    hcount_in = '0; hsync_in = 1'b0;
    tick();
    push(0, "idle_after_reset", 0, 0, 1'b0, 0);

    ypos_player = 11'd10;
    press(); tick();
    push(0, "low_player_drop", 0, 0, 1'b0, 0);
    ypos_player = 11'd700;
    tick();
    push(0, "pending_cleared", 0, 0, 1'b0, 0);

    fire = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      push(0, "held_fire", 11'd530, 11'(684 - 8 * k), 1'b1, 0);
    end
    fire = 1'b0;

`ifdef MISSILE_HIT_EN
    hit = 1'b1; step();
    hit = 1'b0;
    push(0, "hit_in_fly", 11'd530, 11'd652, 1'b0, 0);
    step();
`endif

    for (int w = 0; w < 5 && sb.size() > 0; w++) step();
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
